// File: rtl/bus_timer_responder.sv
// bus_timer_responder: CIA-style memory-mapped timer block on the 6502 bus.
// Decodes a 16-byte window at BASE, returns read data combinationally and
// commits writes on the rising clock edge (single-cycle bus model).
// Contains a 16-bit reloadable down-counter with prescaler, an underflow
// interrupt and a scratch register.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-low reset
//   ab     CPU address bus
//   dout   CPU write data (the CPU's "do" bus; "do" is a reserved word)
//   we     CPU write enable, 1 = write cycle
//   di     read data to CPU, 8'h00 unless a read hits the window
//   sel    window hit, used by the top level to mux di
//   irq    registered active-high interrupt request
module bus_timer_responder #(
    parameter logic [15:0] BASE     = 16'hDC00,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic [7:0]  dout,
    input  logic        we,
    output logic [7:0]  di,
    output logic        sel,
    output logic        irq
);

    localparam logic [7:0] PreLoad = 8'(PRESCALE - 1);

    logic [15:0] latch_q, latch_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  scratch_q, scratch_d;
    logic        start_q, start_d;
    logic        oneshot_q, oneshot_d;
    logic        flag_q, flag_d;
    logic        ien_q, ien_d;
    logic        irq_q, irq_d;

    logic [3:0]  off;
    logic        wr_en, rd_en;
    logic        tick, force_load;

    assign off   = ab[3:0];
    assign sel   = (ab[15:4] == BASE[15:4]);
    assign wr_en = sel & we;
    assign rd_en = sel & ~we;
    assign irq   = irq_q;

    assign tick       = start_q && (pre_q == 8'd0);
    // Force-load takes priority over a same-cycle tick: no decrement, no underflow.
    assign force_load = wr_en && (off == 4'h3) && dout[4];

    always_comb begin
        latch_d   = latch_q;
        count_d   = count_q;
        pre_d     = pre_q;
        scratch_d = scratch_q;
        start_d   = start_q;
        oneshot_d = oneshot_q;
        flag_d    = flag_q;
        ien_d     = ien_q;

        if (!start_q || pre_q == 8'd0) begin
            pre_d = PreLoad;
        end else begin
            pre_d = pre_q - 8'd1;
        end

        // Clear-on-read first so that a same-edge underflow wins.
        if (rd_en && off == 4'h2) begin
            flag_d = 1'b0;
        end

        if (tick && !force_load) begin
            if (count_q == 16'h0000) begin
                count_d = latch_q;
                flag_d  = 1'b1;
                if (oneshot_q) begin
                    start_d = 1'b0;
                end
            end else begin
                count_d = count_q - 16'd1;
            end
        end

        // Bus writes applied last; a CTRL write overrides the one-shot stop.
        if (wr_en) begin
            case (off)
                4'h0: latch_d[7:0] = dout;
                4'h1: begin
                    latch_d[15:8] = dout;
                    if (!start_q) begin
                        count_d = {dout, latch_q[7:0]};
                    end
                end
                4'h2: ien_d = dout[0];
                4'h3: begin
                    start_d   = dout[0];
                    oneshot_d = dout[1];
                    if (dout[4]) begin
                        count_d = latch_q;
                    end
                end
                4'h4: scratch_d = dout;
                default: ;
            endcase
        end

        irq_d = flag_d & ien_d;
    end

    always_comb begin
        di = 8'h00;
        if (rd_en) begin
            case (off)
                4'h0:    di = count_q[7:0];
                4'h1:    di = count_q[15:8];
                4'h2:    di = {irq_q, 6'b0, flag_q};
                4'h3:    di = {6'b0, oneshot_q, start_q};
                4'h4:    di = scratch_q;
                default: di = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            latch_q   <= 16'hFFFF;
            count_q   <= 16'hFFFF;
            pre_q     <= 8'd0;
            scratch_q <= 8'h00;
            start_q   <= 1'b0;
            oneshot_q <= 1'b0;
            flag_q    <= 1'b0;
            ien_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            latch_q   <= latch_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            scratch_q <= scratch_d;
            start_q   <= start_d;
            oneshot_q <= oneshot_d;
            flag_q    <= flag_d;
            ien_q     <= ien_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: doc/bus_timer_responder.md
Name: bus_timer_responder

Overview:
- Memory-mapped peripheral that answers the 6502 core's bus as a responder.
- Decodes a 16-byte window on the CPU address bus and returns read data combinationally. Write data is captured on the clock edge, in the same single-cycle bus model the CPU core uses.
- Contains a 16-bit reloadable down-counter timer with an underflow interrupt and a scratch register. It is the first CIA-style I/O block on the C64 bus; the top level muxes its read data into the CPU data-in path.

Parameters:
- BASE, 16'hDC00, window base address; only BASE[15:4] is compared.
- PRESCALE, 1, clocks per timer tick while running (1..256).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- ab  input  16  CPU address bus.
- do  input  8  CPU write data.
- we  input  1  CPU write enable; 1 = write cycle, 0 = read cycle.
- di  output  8  read data to CPU.
- sel  output  1  window hit; the top level uses it to mux di.
- irq  output  1  interrupt request, active-high, registered.

Behaviour:
- Decode and read path (combinational):
  - sel = (ab[15:4] == BASE[15:4]); off = ab[3:0].
  - di = register value when sel && !we; otherwise 8'h00.
- Write path: every write is committed on the rising clk edge when sel && we.
- Register map:
  - 0x0: R = count[7:0]; W = latch[7:0].
  - 0x1: R = count[15:8]; W = latch[15:8]. If start==0 at that edge, also count <= {do, latch[7:0]}.
  - 0x2 ICR: R = {irq, 6'b0, flag}. A read access (sel && !we && off==2) at an edge clears flag. W: ien <= do[0].
  - 0x3 CTRL: R = {6'b0, oneshot, start}. W: start <= do[0]; oneshot <= do[1]; do[4] = force-load strobe, count <= latch, not stored, reads 0.
  - 0x4 SCRATCH: R/W, 8-bit.
  - 0x5..0xF: read 8'h00; writes ignored.
- Reset (reset==0 at an edge), which overrides everything including a concurrent bus write:
  - latch = 16'hFFFF, count = 16'hFFFF.
  - start = oneshot = flag = ien = 0; scratch = 0; prescaler = 0; irq = 0.
  - di follows the decode, so it reads reset values in the next cycle.
- Prescaler:
  - While start==1, it counts PRESCALE-1 down to 0 and reloads; tick = 1 in the cycle it is 0.
  - While start==0, it is held at PRESCALE-1.
  - With PRESCALE=1, tick = start.
- Counter, on a tick:
  - If count != 0: count <= count - 1.
  - If count == 0 (underflow): count <= latch, flag <= 1, and if oneshot then start <= 0.
  - Period = latch+1 ticks. latch = 0 underflows every tick.
- irq:
  - Registered: irq <= next_flag & next_ien, so it asserts the cycle after the underflow edge.
  - Clearing ien or flag deasserts irq the following cycle.
- Simultaneous events:
  - Force-load and tick in the same cycle: force-load wins; no decrement, no underflow.
  - Underflow and ICR read in the same cycle: flag stays 1 (set wins); the read returns the pre-edge value.
  - Write to 0x0/0x1 in an underflow cycle: the reload uses the old latch.
  - CTRL write setting start=1: counting begins the next cycle.
  - CTRL write clearing start in an underflow cycle: the underflow still completes (reload + flag).
- Width rules:
  - count wraps only via reload, never to 16'hFFFF by decrement.
  - All arithmetic is 16-bit unsigned.

Test Plan:
- Reset: pulse reset low 1 cycle, then read 0x0/0x1/0x2/0x3/0x4 -> FF, FF, 00, 00, 00; irq=0. Access ab=16'hDD00 -> sel=0, di=00.
- Continuous mode (PRESCALE=1):
  - Stimulus: write 0x0=03, 0x1=00 (stopped, so count loads 0003), 0x2=01, 0x3=01.
  - Required: count reads 3,2,1,0,3,2,...; flag set every 4 clocks; irq high one cycle after the first underflow.
- One-shot:
  - Stimulus: latch=0002, CTRL=03.
  - Required: exactly one underflow after 3 ticks; start reads 0 afterwards; count holds 0002; flag=1.
- ICR clear-on-read:
  - After an underflow, read 0x2 -> 81; the next read -> 00 and irq drops.
  - Repeat with the read coinciding with the underflow edge -> flag remains 1.
- Force-load and running-write:
  - While running with latch=0010, write 0x1=00 -> count unaffected.
  - Write CTRL=11 -> count reads 0010 the next cycle, with no underflow that cycle.
- Scratch and decode:
  - Write 0x4=5A, then read -> 5A.
  - Write 16'hDC0F=77 and 16'hDB04=33 -> scratch still 5A; 0xF reads 00.
  - PRESCALE=4 build: count decrements every 4 clocks.
